// File: rtl/reg_dump_reader.sv
// Register-file dump initiator: walks registers FIRST..LAST through the read port
// and streams each captured word out on a valid/ready handshake.
module reg_dump_reader #(
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int FIRST = 0,
  parameter int LAST  = 2**D-1
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  output logic         Busy,
  output logic         Done,
  output logic [D-1:0] Rd_address,
  input  logic [W-1:0] Rd_data,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [W-1:0] Out_data,
  output logic [D-1:0] Out_address
);

  localparam logic [D-1:0] FIRST_IDX = D'(FIRST);
  localparam logic [D-1:0] LAST_IDX  = D'(LAST);

  generate
    if (FIRST < 0 || FIRST > LAST || LAST > 2**D-1) begin : g_bad_range
      $error("reg_dump_reader: register range FIRST..LAST is empty or out of bounds");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state;
  state_t       next_state;
  logic [D-1:0] ptr;
  logic         xfer;
  logic         at_last;
  logic         capture;
  logic         finish;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = SEND;
      SEND:    if (finish) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The last-index compare precedes the increment, so ptr never overflows.
  always_comb begin
    Busy       = (state == SEND);
    Out_valid  = (state == SEND);
    xfer       = (state == SEND) && Out_ready;
    at_last    = (ptr == LAST_IDX);
    finish     = xfer && at_last;
    capture    = ((state == IDLE) && Start) || (xfer && !at_last);
    Rd_address = (xfer && !at_last) ? ptr + 1'b1 : ptr;
  end

  // Capturing on the edge gives a snapshot: later register writes leave a held word intact.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ptr         <= FIRST_IDX;
      Out_data    <= '0;
      Out_address <= '0;
      Done        <= 1'b0;
    end else begin
      Done <= finish;
      if (capture) begin
        Out_data    <= Rd_data;
        Out_address <= Rd_address;
        ptr         <= Rd_address;
      end else if (finish) begin
        ptr <= FIRST_IDX;
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: per-cycle control table plus a word scoreboard
// fed from a behavioural register file.
module tb_reg_dump_reader;

  typedef struct {
    logic       start;
    logic       ready;
    logic       busy;
    logic       valid;
    logic       done;
    logic [2:0] addr;
  } vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } word_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] rd_address;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_address;

  logic       start2;
  logic       busy2;
  logic       done2;
  logic [2:0] rd_address2;
  logic [7:0] rd_data2;
  logic       out_valid2;
  logic       out_ready2;
  logic [7:0] out_data2;
  logic [2:0] out_address2;

  logic [7:0] regs [8];
  vec_t       vecs [$];
  word_t      sb [$];
  int         total = 0;
  int         bad   = 0;
  int         beats = 0;

  assign rd_data  = regs[rd_address];
  assign rd_data2 = regs[rd_address2];

  reg_dump_reader #(.W(8), .D(3), .FIRST(0), .LAST(7)) dut (
    .CLK(clk), .Reset(reset), .Start(start), .Busy(busy), .Done(done),
    .Rd_address(rd_address), .Rd_data(rd_data), .Out_valid(out_valid),
    .Out_ready(out_ready), .Out_data(out_data), .Out_address(out_address)
  );

  reg_dump_reader #(.W(8), .D(3), .FIRST(2), .LAST(2)) dut2 (
    .CLK(clk), .Reset(reset), .Start(start2), .Busy(busy2), .Done(done2),
    .Rd_address(rd_address2), .Rd_data(rd_data2), .Out_valid(out_valid2),
    .Out_ready(out_ready2), .Out_data(out_data2), .Out_address(out_address2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #1;
    start     = s;
    out_ready = r;
  endtask

  task automatic addRow(input logic s, input logic r, input logic b, input logic v,
                        input logic d, input logic [2:0] a);
    vec_t row;
    row.start = s; row.ready = r; row.busy = b; row.valid = v; row.done = d; row.addr = a;
    vecs.push_back(row);
  endtask

  task automatic pushWord(input logic [2:0] a, input logic [7:0] d);
    word_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  // Every accepted beat must match the next expected word, in order.
  initial begin : monitor
    word_t w;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        beats++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got addr %0h data %0h, no word expected",
                   out_address, out_data);
        end else begin
          w = sb.pop_front();
          checkOutput("beat_addr", 32'(out_address), 32'(w.addr));
          checkOutput("beat_data", 32'(out_data), 32'(w.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       pat [4];
    logic       held;
    logic [2:0] held_addr;
    logic [7:0] held_data;
    logic       seen;
    int         b0;

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; start2 = 1'b0; out_ready2 = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Pulsed Start, then Start held through a whole dump and into its Done cycle.
    addRow(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) addRow(0, 1, 1, 1, 0, 3'(i));
    addRow(0, 1, 0, 0, 1, 0);
    addRow(0, 1, 0, 0, 0, 0);
    addRow(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) addRow(1, 1, 1, 1, 0, 3'(i));
    addRow(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) addRow(0, 1, 1, 1, 0, 3'(i));
    addRow(0, 1, 0, 0, 1, 0);
    addRow(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) pushWord(3'(i % 8), 8'h10 + 8'(i % 8));

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_data", 32'(out_data), 0);
    checkOutput("rst_addr", 32'(out_address), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].ready);
      @(negedge clk);
      checkOutput($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      checkOutput($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      checkOutput($sformatf("row%0d_done", i), 32'(done), 32'(vecs[i].done));
      if (vecs[i].valid)
        checkOutput($sformatf("row%0d_addr", i), 32'(out_address), 32'(vecs[i].addr));
    end
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("table_sb_drained", sb.size(), 0);

    // Stall pattern 1,0,0,1: held words must not change, no drops or duplicates.
    for (int i = 0; i < 8; i++) pushWord(3'(i), 8'h10 + 8'(i));
    b0 = beats;
    held = 1'b0; seen = 1'b0; held_addr = '0; held_data = '0;
    applyStimulus(1, 1);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(0, pat[k % 4]);
      @(negedge clk);
      if (held) begin
        checkOutput("stall_addr_stable", 32'(out_address), 32'(held_addr));
        checkOutput("stall_data_stable", 32'(out_data), 32'(held_data));
      end
      held      = out_valid && !out_ready;
      held_addr = out_address;
      held_data = out_data;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("stall_done_seen", 32'(seen), 1);
    checkOutput("stall_beats", beats - b0, 8);
    checkOutput("stall_sb_drained", sb.size(), 0);

    // Reset asserted while stalled on address 4.
    for (int i = 0; i < 4; i++) pushWord(3'(i), 8'h10 + 8'(i));
    applyStimulus(1, 1);
    repeat (4) applyStimulus(0, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("pre_rst_valid", 32'(out_valid), 1);
    checkOutput("pre_rst_addr", 32'(out_address), 4);
    checkOutput("pre_rst_data", 32'(out_data), 32'h14);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 0);
    checkOutput("async_rst_busy", 32'(busy), 0);
    checkOutput("async_rst_done", 32'(done), 0);
    checkOutput("async_rst_addr", 32'(out_address), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      applyStimulus(0, 1);
      @(negedge clk);
      checkOutput("post_rst_idle_valid", 32'(out_valid), 0);
      checkOutput("post_rst_idle_busy", 32'(busy), 0);
    end
    checkOutput("rst_sb_drained", sb.size(), 0);

    // Snapshot: write to a held word is invisible, write ahead of capture is seen.
    for (int i = 0; i < 8; i++) pushWord(3'(i), (i == 5) ? 8'hBB : 8'h10 + 8'(i));
    applyStimulus(1, 1);
    repeat (3) applyStimulus(0, 1);
    applyStimulus(0, 0);
    regs[3] = 8'hAA;
    regs[5] = 8'hBB;
    @(negedge clk);
    checkOutput("snap_addr", 32'(out_address), 3);
    checkOutput("snap_data_held", 32'(out_data), 32'h13);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("snap_data_still_held", 32'(out_data), 32'h13);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("snap_done_seen", 32'(seen), 1);
    checkOutput("snap_sb_drained", sb.size(), 0);
    regs[3] = 8'h13;
    regs[5] = 8'h15;

    // Single-register range on the second instance.
    @(posedge clk);
    #1 start2 = 1'b1; out_ready2 = 1'b1;
    @(negedge clk);
    checkOutput("one_idle_busy", 32'(busy2), 0);
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    checkOutput("one_busy", 32'(busy2), 1);
    checkOutput("one_valid", 32'(out_valid2), 1);
    checkOutput("one_addr", 32'(out_address2), 2);
    checkOutput("one_data", 32'(out_data2), 32'h12);
    checkOutput("one_done_early", 32'(done2), 0);
    @(negedge clk);
    checkOutput("one_done", 32'(done2), 1);
    checkOutput("one_busy_after", 32'(busy2), 0);
    checkOutput("one_valid_after", 32'(out_valid2), 0);
    @(negedge clk);
    checkOutput("one_done_pulse", 32'(done2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
